sys_arb_rr: RTL and testbench

//  Round-robin, packet-locking arbiter that shares one valid/ready stream sink among N_REQ

---
 rtl/sys_arb_rr.sv | 117 +++++++++++
 tb/tb_sys_arb_rr.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sys_arb_rr.sv
// Round-robin, packet-locking arbiter sharing one valid/ready sink among N_REQ requesters.
// Arbitration costs one idle cycle; the output side is a single registered stage.
//
//   state | meaning
//   IDLE  | no owner; pick the first valid requester from ptr upward, nothing accepted
//   LOCK  | grant owns the sink; beats flow until the packet (or beat) completes
module sys_arb_rr #(
  parameter int N_REQ    = 4,
  parameter int DATA_W   = 32,
  parameter bit PKT_LOCK = 1'b1,
  localparam int GID_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        s_valid,
  output logic [N_REQ-1:0]        s_ready,
  input  logic [N_REQ*DATA_W-1:0] s_data,
  input  logic [N_REQ-1:0]        s_last,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [DATA_W-1:0]       m_data,
  output logic                    m_last,
  output logic [GID_W-1:0]        m_id,
  output logic                    busy
);

  localparam int IW = GID_W + 1;

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [GID_W-1:0] grant_q, grant_d;
  logic [GID_W-1:0] ptr_q, ptr_d;
  logic [GID_W-1:0] pick;
  logic             pick_ok;
  logic [IW-1:0]    idx;
  logic             out_free;
  logic             load;

  assign out_free = !m_valid || m_ready;
  assign load     = (state_q == LOCK) && s_valid[grant_q] && out_free;
  assign busy     = (state_q == LOCK);

  always_comb begin
    s_ready = '0;
    if (state_q == LOCK) s_ready[grant_q] = out_free;
  end

  // Rotating priority search starting at ptr, wrapping modulo N_REQ.
  always_comb begin
    pick    = ptr_q;
    pick_ok = 1'b0;
    idx     = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = {1'b0, ptr_q} + IW'(k);
      if (idx >= IW'(N_REQ)) idx = idx - IW'(N_REQ);
      if (!pick_ok && s_valid[idx[GID_W-1:0]]) begin
        pick    = idx[GID_W-1:0];
        pick_ok = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        if (pick_ok) begin
          grant_d = pick;
          state_d = LOCK;
        end
      end
      LOCK: begin
        if (load && (s_last[grant_q] || !PKT_LOCK)) begin
          state_d = IDLE;
          ptr_d   = (grant_q == GID_W'(N_REQ - 1)) ? '0 : grant_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
    end
  end

  // m_* only change on a load; a stalled beat stays put until m_ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_data  <= '0;
      m_last  <= 1'b0;
      m_id    <= '0;
    end else if (load) begin
      m_valid <= 1'b1;
      m_data  <= s_data[grant_q*DATA_W +: DATA_W];
      m_last  <= s_last[grant_q];
      m_id    <= grant_q;
    end else if (m_ready) begin
      m_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sys_arb_rr.sv
// Bench for sys_arb_rr: a packet-locked and a per-beat instance side by side, checked every
// cycle against a behavioural model, plus directed scenarios with literal expectations.
module tb_sys_arb_rr;
  localparam int N  = 4;
  localparam int W  = 32;
  localparam int GW = 2;

  typedef struct {
    int          id;
    logic [W-1:0] d;
    bit          l;
    int          cyc;
  } beat_t;

  logic           clk;
  logic           rst_n;
  logic [N-1:0]   s_valid [2];
  logic [N-1:0]   s_last  [2];
  logic [N*W-1:0] s_data  [2];
  logic           m_ready [2];
  logic [N-1:0]   s_ready [2];
  logic           m_valid [2];
  logic [W-1:0]   m_data  [2];
  logic           m_last  [2];
  logic [GW-1:0]  m_id    [2];
  logic           busy    [2];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  beat_t        out_log [2][$];
  logic [W:0]   sent_q  [2*N][$];
  logic [N-1:0] acc     [2];

  // Reference state: owner lock, owner, rotation pointer, output stage contents.
  bit           pk  [2] = '{1'b1, 1'b0};
  bit           lk  [2];
  int           own [2];
  int           ptr [2];
  bit           mv  [2];
  bit           ml  [2];
  logic [W-1:0] md  [2];
  int           mid [2];

  sys_arb_rr #(.N_REQ(N), .DATA_W(W), .PKT_LOCK(1'b1)) u_lock (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid[0]), .s_ready(s_ready[0]), .s_data(s_data[0]), .s_last(s_last[0]),
    .m_valid(m_valid[0]), .m_ready(m_ready[0]), .m_data(m_data[0]), .m_last(m_last[0]),
    .m_id(m_id[0]), .busy(busy[0])
  );

  sys_arb_rr #(.N_REQ(N), .DATA_W(W), .PKT_LOCK(1'b0)) u_beat (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid[1]), .s_ready(s_ready[1]), .s_data(s_data[1]), .s_last(s_last[1]),
    .m_valid(m_valid[1]), .m_ready(m_ready[1]), .m_data(m_data[1]), .m_last(m_last[1]),
    .m_id(m_id[1]), .busy(busy[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int u = 0; u < 2; u++) begin
      lk[u] = 1'b0; own[u] = 0; ptr[u] = 0;
      mv[u] = 1'b0; ml[u] = 1'b0; md[u] = '0; mid[u] = 0;
    end
  endtask

  task automatic model_step();
    for (int u = 0; u < 2; u++) begin
      bit fire;
      fire = lk[u] && s_valid[u][own[u]] && (!mv[u] || m_ready[u]);
      if (fire) begin
        mv[u]  = 1'b1;
        md[u]  = s_data[u][own[u]*W +: W];
        ml[u]  = s_last[u][own[u]];
        mid[u] = own[u];
      end else if (m_ready[u]) begin
        mv[u] = 1'b0;
      end
      if (!lk[u]) begin
        for (int k = 0; k < N; k++)
          if (!lk[u] && s_valid[u][(ptr[u] + k) % N]) begin
            own[u] = (ptr[u] + k) % N;
            lk[u]  = 1'b1;
          end
      end else if (fire && (s_last[u][own[u]] || !pk[u])) begin
        lk[u]  = 1'b0;
        ptr[u] = (own[u] + 1) % N;
      end
    end
  endtask

  // Compare process: outputs checked every cycle just after the falling edge.
  initial begin
    model_reset();
    forever begin
      @(negedge clk);
      #1;
      if (!rst_n) model_reset();
      for (int u = 0; u < 2; u++) begin
        logic [N-1:0] er;
        er = '0;
        if (lk[u] && (!mv[u] || m_ready[u])) er[own[u]] = 1'b1;
        chk($sformatf("u%0d s_ready", u), 64'(s_ready[u]), 64'(er));
        chk($sformatf("u%0d m_valid", u), 64'(m_valid[u]), 64'(mv[u]));
        chk($sformatf("u%0d m_data", u), 64'(m_data[u]), 64'(md[u]));
        chk($sformatf("u%0d m_last", u), 64'(m_last[u]), 64'(ml[u]));
        chk($sformatf("u%0d m_id", u), 64'(m_id[u]), 64'(mid[u]));
        chk($sformatf("u%0d busy", u), 64'(busy[u]), 64'(lk[u]));
        if (rst_n) begin
          acc[u] = s_valid[u] & s_ready[u];
          for (int i = 0; i < N; i++)
            if (acc[u][i]) sent_q[u*N+i].push_back({s_last[u][i], s_data[u][i*W +: W]});
          if (m_valid[u] && m_ready[u])
            out_log[u].push_back('{int'(m_id[u]), m_data[u], m_last[u], cyc});
        end else begin
          acc[u] = '0;
        end
      end
      @(posedge clk);
      if (!rst_n) model_reset();
      else model_step();
      cyc++;
    end
  end

  task automatic clear_inputs();
    for (int u = 0; u < 2; u++) begin
      s_valid[u] = '0;
      s_last[u]  = '0;
      s_data[u]  = '0;
      m_ready[u] = 1'b1;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    clear_inputs();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Called at a falling edge; returns at the falling edge after the beat was taken.
  task automatic send_beat(input int u, input int i, input logic [W-1:0] d, input bit l);
    int n;
    n = 0;
    s_valid[u][i]          = 1'b1;
    s_data[u][i*W +: W]    = d;
    s_last[u][i]           = l;
    #2;
    while (!s_ready[u][i] && n < 200) begin
      @(negedge clk);
      #2;
      n++;
    end
    if (n >= 200) chk($sformatf("u%0d req%0d accept timeout", u, i), 64'(n), 64'(0));
    @(negedge clk);
    s_valid[u][i] = 1'b0;
  endtask

  task automatic send_pkts(input int u, input int i, input int npk, input int len,
                           input logic [W-1:0] base);
    for (int p = 0; p < npk; p++)
      for (int b = 0; b < len; b++)
        send_beat(u, i, base + W'(p*16 + b), (b == len - 1));
  endtask

  function automatic beat_t get_beat(input int u, input int j);
    beat_t e;
    e = '{-1, '0, 1'b0, -1};
    if (j < out_log[u].size()) e = out_log[u][j];
    return e;
  endfunction

  initial begin
    int         mark;
    int         c0;
    int         nb;
    int         rsum;
    int         mark_o [2];
    int         mark_s [2*N];
    int         rem    [2][N];
    logic [W:0] got [$];
    beat_t      e;
    bit         stop;

    rst_n = 1'b0;
    clear_inputs();

    // 1: reset, then idle outputs for 10 clocks
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) begin
      @(negedge clk);
      #2;
      for (int u = 0; u < 2; u++) begin
        chk("t1 m_valid", 64'(m_valid[u]), 64'(0));
        chk("t1 busy", 64'(busy[u]), 64'(0));
        chk("t1 s_ready", 64'(s_ready[u]), 64'(0));
      end
    end

    // 2: req1 sends A1,A2,A3
    mark = out_log[0].size();
    c0   = cyc;
    s_valid[0][1]       = 1'b1;
    s_data[0][1*W +: W] = 32'hA1;
    s_last[0][1]        = 1'b0;
    @(negedge clk);
    #2;
    chk("t2 busy at t+1", 64'(busy[0]), 64'(1));
    chk("t2 s_ready at t+1", 64'(s_ready[0]), 64'(4'b0010));
    @(negedge clk);
    send_beat(0, 1, 32'hA2, 1'b0);
    send_beat(0, 1, 32'hA3, 1'b1);
    repeat (3) @(negedge clk);
    chk("t2 beat count", 64'(out_log[0].size() - mark), 64'(3));
    for (int j = 0; j < 3; j++) begin
      e = get_beat(0, mark + j);
      chk("t2 data", 64'(e.d), 64'(32'hA1 + j));
      chk("t2 id", 64'(e.id), 64'(1));
      chk("t2 last", 64'(e.l), 64'(j == 2));
      chk("t2 cycle", 64'(e.cyc), 64'(c0 + 2 + j));
    end

    // 3: all four requesters, continuous 2-beat packets from ptr=0
    do_reset();
    mark = out_log[0].size();
    fork
      send_pkts(0, 0, 2, 2, 32'h300);
      send_pkts(0, 1, 2, 2, 32'h310);
      send_pkts(0, 2, 2, 2, 32'h320);
      send_pkts(0, 3, 2, 2, 32'h330);
    join
    repeat (3) @(negedge clk);
    chk("t3 beat count", 64'(out_log[0].size() - mark), 64'(16));
    for (int j = 0; j < 10; j++) begin
      e = get_beat(0, mark + j);
      chk("t3 grant order", 64'(e.id), 64'((j / 2) % 4));
      if (j > 0) chk("t3 spacing", 64'(e.cyc - get_beat(0, mark + j - 1).cyc),
                     64'((j % 2 == 1) ? 1 : 2));
    end

    // 4: per-beat arbitration, req0 and req2 four beats each
    mark = out_log[1].size();
    fork
      send_pkts(1, 0, 1, 4, 32'h400);
      send_pkts(1, 2, 1, 4, 32'h420);
    join
    repeat (3) @(negedge clk);
    chk("t4 beat count", 64'(out_log[1].size() - mark), 64'(8));
    for (int j = 0; j < 8; j++) begin
      e = get_beat(1, mark + j);
      chk("t4 alternate", 64'(e.id), 64'((j % 2 == 0) ? 0 : 2));
      chk("t4 data", 64'(e.d), 64'(((j % 2 == 0) ? 32'h400 : 32'h420) + W'(j / 2)));
      if (j > 0) chk("t4 spacing", 64'(e.cyc - get_beat(1, mark + j - 1).cyc), 64'(2));
    end

    // 5: 5-clock stall on the first beat of a 4-beat packet
    mark = out_log[0].size();
    fork
      send_pkts(0, 3, 1, 4, 32'h500);
      begin
        nb = 0;
        while (!m_valid[0] && nb < 50) begin
          @(negedge clk);
          nb++;
        end
        chk("t5 first beat wait", 64'(nb < 50), 64'(1));
        m_ready[0] = 1'b0;
        for (int s = 0; s < 5; s++) begin
          #2;
          chk("t5 stall m_data", 64'(m_data[0]), 64'(32'h500));
          chk("t5 stall m_valid", 64'(m_valid[0]), 64'(1));
          chk("t5 stall s_ready", 64'(s_ready[0]), 64'(0));
          @(negedge clk);
        end
        m_ready[0] = 1'b1;
      end
    join
    repeat (3) @(negedge clk);
    chk("t5 beat count", 64'(out_log[0].size() - mark), 64'(4));
    for (int j = 0; j < 4; j++) begin
      e = get_beat(0, mark + j);
      chk("t5 data", 64'(e.d), 64'(32'h500 + j));
      chk("t5 id", 64'(e.id), 64'(3));
      chk("t5 last", 64'(e.l), 64'(j == 3));
    end

    // 6: reset mid-packet, then arbitration restarts from ptr=0
    send_pkts(0, 1, 1, 1, 32'h610);
    send_beat(0, 2, 32'h620, 1'b0);
    send_beat(0, 2, 32'h621, 1'b0);
    s_valid[0][2]       = 1'b1;
    s_data[0][2*W +: W] = 32'h622;
    #2;
    chk("t6 pre-reset m_valid", 64'(m_valid[0]), 64'(1));
    #1;
    rst_n = 1'b0;
    #1;
    chk("t6 async m_valid", 64'(m_valid[0]), 64'(0));
    chk("t6 async busy", 64'(busy[0]), 64'(0));
    chk("t6 async s_ready", 64'(s_ready[0]), 64'(0));
    clear_inputs();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    mark = out_log[0].size();
    s_valid[0][1] = 1'b1; s_data[0][1*W +: W] = 32'h631; s_last[0][1] = 1'b1;
    s_valid[0][3] = 1'b1; s_data[0][3*W +: W] = 32'h633; s_last[0][3] = 1'b1;
    @(negedge clk);
    #2;
    chk("t6 grant after reset", 64'(s_ready[0]), 64'(4'b0010));
    @(negedge clk);
    s_valid[0][1] = 1'b0;
    send_beat(0, 3, 32'h633, 1'b1);
    repeat (3) @(negedge clk);
    chk("t6 first id", 64'(get_beat(0, mark).id), 64'(1));
    chk("t6 first data", 64'(get_beat(0, mark).d), 64'(32'h631));
    chk("t6 second id", 64'(get_beat(0, mark + 1).id), 64'(3));

    // Random traffic with backpressure and occasional valid drops, then drain
    for (int u = 0; u < 2; u++) begin
      mark_o[u] = out_log[u].size();
      for (int i = 0; i < N; i++) begin
        mark_s[u*N+i] = sent_q[u*N+i].size();
        rem[u][i]     = 0;
      end
    end
    for (int c = 0; c < 2600; c++) begin
      @(negedge clk);
      stop = (c >= 2000);
      for (int u = 0; u < 2; u++) begin
        for (int i = 0; i < N; i++) begin
          if (acc[u][i]) begin
            rem[u][i]--;
            s_valid[u][i] = 1'b0;
          end else if (s_valid[u][i] && $urandom_range(15) == 0) begin
            s_valid[u][i] = 1'b0;
          end
          if (!s_valid[u][i]) begin
            if (rem[u][i] == 0 && !stop && $urandom_range(3) == 0)
              rem[u][i] = $urandom_range(4, 1);
            if (rem[u][i] > 0 && $urandom_range(3) != 0) begin
              s_valid[u][i]       = 1'b1;
              s_data[u][i*W +: W] = $urandom;
              s_last[u][i]        = (rem[u][i] == 1);
            end
          end
        end
        m_ready[u] = stop ? 1'b1 : ($urandom_range(3) != 0);
      end
    end
    @(negedge clk);
    rsum = 0;
    for (int u = 0; u < 2; u++)
      for (int i = 0; i < N; i++) begin
        if (acc[u][i]) rem[u][i]--;
        rsum += rem[u][i];
      end
    clear_inputs();
    repeat (5) @(negedge clk);
    chk("random drain", 64'(rsum), 64'(0));
    for (int u = 0; u < 2; u++) begin
      chk("random activity", 64'(out_log[u].size() - mark_o[u] > 200), 64'(1));
      for (int i = 0; i < N; i++) begin
        got.delete();
        for (int j = mark_o[u]; j < out_log[u].size(); j++)
          if (out_log[u][j].id == i) got.push_back({out_log[u][j].l, out_log[u][j].d});
        chk($sformatf("u%0d req%0d beat conservation", u, i), 64'(got.size()),
            64'(sent_q[u*N+i].size() - mark_s[u*N+i]));
        nb = 0;
        for (int j = 0; j < got.size() && mark_s[u*N+i] + j < sent_q[u*N+i].size(); j++)
          if (got[j] !== sent_q[u*N+i][mark_s[u*N+i] + j]) nb++;
        chk($sformatf("u%0d req%0d beat order", u, i), 64'(nb), 64'(0));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
